ssd1306_7seg_frame_streamer: RTL and testbench

//  Renders a row of NUM_DIGITS seven-segment digits (32 px high, DIGIT_W px wide) into
//  SSD1306 page-format bytes (1 byte = 8 vertical px, LSB = top row).

---
 rtl/ssd1306_7seg_frame_streamer.sv | 161 ++++++++++++++++
 tb/tb_ssd1306_7seg_frame_streamer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_7seg_frame_streamer.sv
// rtl/ssd1306_7seg_frame_streamer.sv - seven-segment digit row rendered to SSD1306 page bytes
// Captures a digit frame, then streams 4 pages of LINE_W bytes over a valid/ready handshake.
module ssd1306_7seg_frame_streamer #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 21,
  parameter int GAP_W      = 3,
  parameter int SEG_T      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7*NUM_DIGITS-1:0] segments_in,
  input  logic [NUM_DIGITS-1:0]   dec_point_in,
  input  logic                    blank_lz_in,
  output logic [7:0]              byte_out,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CELL_W = DIGIT_W + GAP_W;
  localparam int LINE_W = NUM_DIGITS * CELL_W;
  localparam int COL_W  = $clog2(LINE_W);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

  state_t state, next_state;

  logic [7*NUM_DIGITS-1:0] seg_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic                    blz_sh;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    blank_run;

  // cur_* addresses the byte presently held in byte_out
  logic [1:0]       cur_page, nxt_page, gen_page;
  logic [COL_W-1:0] cur_col, nxt_col, gen_col;
  logic             last_byte;
  logic             handshake;
  logic [7:0]       gen_byte;
  logic [6:0]       cell_seg;
  logic             cell_dp;
  logic             cell_blank;
  int               cell_idx;
  int               cell_x;
  int               digit_idx;

  function automatic logic glyph_px(input int x, input int y, input logic [6:0] s, input logic dp);
    logic hmid, left, right, upper, lower;
    hmid  = (x >= SEG_T) && (x <= DIGIT_W - 1 - SEG_T);
    left  = (x < SEG_T);
    right = (x >= DIGIT_W - SEG_T) && (x < DIGIT_W);
    upper = (y >= SEG_T) && (y <= 15);
    lower = (y >= 16) && (y <= 31 - SEG_T);
    if (x >= DIGIT_W)
      return dp && (x <= DIGIT_W + 1) && (y >= 28);
    return (s[0] && hmid && (y < SEG_T))
        || (s[6] && hmid && (y >= 16 - SEG_T / 2) && (y <= 16 - SEG_T / 2 + SEG_T - 1))
        || (s[3] && hmid && (y >= 32 - SEG_T))
        || (s[5] && left && upper) || (s[4] && left && lower)
        || (s[1] && right && upper) || (s[2] && right && lower);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  assign handshake = byte_valid && byte_ready;
  assign last_byte = (cur_page == 2'd3) && (cur_col == LAST_COL);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_LOAD;
      S_LOAD:   next_state = S_STREAM;
      S_STREAM: if (handshake && last_byte) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  // Blanking walks in from the leftmost digit and stops at the first non-"0" or dotted digit
  always_comb begin
    blank     = '0;
    blank_run = blz_sh;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      blank_run = blank_run && (seg_sh[7*k +: 7] == 7'h3F) && !dp_sh[k];
      blank[k]  = blank_run;
    end
  end

  always_comb begin
    if (cur_col == LAST_COL) begin
      nxt_col  = '0;
      nxt_page = cur_page + 2'd1;
    end else begin
      nxt_col  = cur_col + 1'b1;
      nxt_page = cur_page;
    end
  end

  always_comb begin
    gen_page   = (state == S_LOAD) ? 2'd0 : nxt_page;
    gen_col    = (state == S_LOAD) ? '0 : nxt_col;
    cell_idx   = int'(gen_col) / CELL_W;
    cell_x     = int'(gen_col) % CELL_W;
    digit_idx  = NUM_DIGITS - 1 - cell_idx;
    cell_seg   = '0;
    cell_dp    = 1'b0;
    cell_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == k) begin
        cell_seg   = seg_sh[7*k +: 7];
        cell_dp    = dp_sh[k];
        cell_blank = blank[k];
      end
    end
    gen_byte = '0;
    for (int b = 0; b < 8; b++)
      gen_byte[b] = !cell_blank && glyph_px(cell_x, 8 * int'(gen_page) + b, cell_seg, cell_dp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sh     <= '0;
      dp_sh      <= '0;
      blz_sh     <= 1'b0;
      cur_page   <= '0;
      cur_col    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        seg_sh <= segments_in;
        dp_sh  <= dec_point_in;
        blz_sh <= blank_lz_in;
      end
      if (state == S_LOAD) begin
        cur_page   <= '0;
        cur_col    <= '0;
        byte_out   <= gen_byte;
        byte_valid <= 1'b1;
      end else if (state == S_STREAM && handshake) begin
        if (last_byte) begin
          byte_valid <= 1'b0;
        end else begin
          cur_page <= nxt_page;
          cur_col  <= nxt_col;
          byte_out <= gen_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_7seg_frame_streamer.sv
// tb/tb_ssd1306_7seg_frame_streamer.sv - scoreboard bench for the seven-segment frame streamer
module tb_ssd1306_7seg_frame_streamer;

  localparam int ND     = 4;
  localparam int DW     = 21;
  localparam int GW     = 3;
  localparam int ST     = 3;
  localparam int CELL_W = DW + GW;
  localparam int LINE_W = ND * CELL_W;
  localparam int FRAME  = 4 * LINE_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [7*ND-1:0] segments_in;
  logic [ND-1:0]   dec_point_in;
  logic            blank_lz_in;
  logic [7:0]      byte_out;
  logic            byte_valid;
  logic            byte_ready;
  logic            busy;
  logic            frame_done;

  ssd1306_7seg_frame_streamer #(.NUM_DIGITS(ND), .DIGIT_W(DW), .GAP_W(GW), .SEG_T(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .segments_in(segments_in),
    .dec_point_in(dec_point_in), .blank_lz_in(blank_lz_in), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ready_mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx[FRAME];
  int         hs_count = 0;
  int         first_hs = 0;
  int         last_hs = 0;
  int         done_cnt = 0;
  int         done_cycle = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_byte = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pixel reference built from the segment rectangles (x0,x1,y0,y1 inclusive)
  function automatic logic model_px(input logic [6:0] s, input logic dp, input int x, input int y);
    int r[4];
    if (x >= DW) return dp && x <= DW + 1 && y >= 28 && y <= 31;
    for (int seg = 0; seg < 7; seg++) begin
      case (seg)
        0: r = '{ST, DW-1-ST, 0, ST-1};
        1: r = '{DW-ST, DW-1, ST, 15};
        2: r = '{DW-ST, DW-1, 16, 31-ST};
        3: r = '{ST, DW-1-ST, 32-ST, 31};
        4: r = '{0, ST-1, 16, 31-ST};
        5: r = '{0, ST-1, ST, 15};
        default: r = '{ST, DW-1-ST, 16-ST/2, 16-ST/2+ST-1};
      endcase
      if (s[seg] && x >= r[0] && x <= r[1] && y >= r[2] && y <= r[3]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic push_frame(input logic [7*ND-1:0] s, input logic [ND-1:0] d, input logic blz);
    bit blank[ND];
    int k;
    logic [7:0] b;
    foreach (blank[i]) blank[i] = 0;
    k = ND - 1;
    while (blz && k > 0 && s[7*k +: 7] == 7'h3F && !d[k]) begin
      blank[k] = 1;
      k--;
    end
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < LINE_W; c++) begin
        int dig;
        dig = ND - 1 - c / CELL_W;
        b = 8'h00;
        for (int bit_i = 0; bit_i < 8; bit_i++)
          if (!blank[dig] && model_px(s[7*dig +: 7], d[dig], c % CELL_W, 8*p + bit_i)) b[bit_i] = 1'b1;
        exp_q.push_back(b);
      end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: byte_ready = 1'b1;
      1: byte_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: byte_ready = ($urandom % 4) != 0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_held", int'(byte_valid), 1);
        chk("stall_byte_held", int'(byte_out), int'(stall_byte));
      end
      if (frame_done) begin
        done_cnt++;
        done_cycle = cyc;
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
        else chk("byte", int'(byte_out), int'(exp_q.pop_front()));
        if (hs_count < FRAME) rx[hs_count] = byte_out;
        if (hs_count == 0) first_hs = cyc;
        last_hs = cyc;
        hs_count++;
      end
      stall_prev = byte_valid && !byte_ready;
      stall_byte = byte_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int prev, n;
    prev = done_cnt;
    n = 0;
    while (done_cnt == prev && n < 5000) begin
      step();
      n++;
    end
    if (done_cnt == prev) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input string name, input logic [7*ND-1:0] s, input logic [ND-1:0] d,
                           input logic blz, input bit perturb);
    logic [31:0] r;
    segments_in = s; dec_point_in = d; blank_lz_in = blz;
    push_frame(s, d, blz);
    hs_count = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    if (perturb) begin
      repeat (20) step();
      r = $urandom; segments_in = r[7*ND-1:0];
      r = $urandom; dec_point_in = r[ND-1:0]; blank_lz_in = r[8];
    end
    wait_done(name);
    chk({name, "_handshakes"}, hs_count, FRAME);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  function automatic int nonzero(input int c0, input int c1);
    int n = 0;
    for (int p = 0; p < 4; p++)
      for (int c = c0; c <= c1; c++) if (rx[p*LINE_W + c] != 8'h00) n++;
    return n;
  endfunction

  initial begin
    logic [31:0] r;
    int saved_done, n;
    rst_n = 1'b0; start = 1'b0; byte_ready = 1'b1;
    segments_in = '0; dec_point_in = '0; blank_lz_in = 1'b0;
    repeat (3) step();
    chk("reset_valid", int'(byte_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(frame_done), 0);
    chk("reset_byte", int'(byte_out), 0);
    rst_n = 1'b1;
    step();

    // All segments lit, full-rate sink: latency and no-bubble streaming
    segments_in = {ND{7'h7F}}; dec_point_in = '0;
    push_frame(segments_in, dec_point_in, 1'b0);
    hs_count = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("latency_busy", int'(busy), 1);
    chk("latency_valid_early", int'(byte_valid), 0);
    step();
    chk("latency_valid", int'(byte_valid), 1);
    wait_done("all8");
    chk("all8_handshakes", hs_count, FRAME);
    chk("all8_no_bubbles", last_hs - first_hs, FRAME - 1);
    chk("all8_done_timing", done_cycle, last_hs + 1);
    chk("all8_idle_after", int'(busy), 0);

    run_frame("left8", {7'h7F, {(ND-1){7'h00}}}, '0, 1'b0, 0);
    chk("left8_p0c0", int'(rx[0]), 'hF8);
    chk("left8_p0c5", int'(rx[5]), 'h07);
    chk("left8_p1c0", int'(rx[LINE_W]), 'hFF);
    chk("left8_p1c5", int'(rx[LINE_W+5]), 'h80);
    chk("left8_p2c5", int'(rx[2*LINE_W+5]), 'h03);
    chk("left8_p3c0", int'(rx[3*LINE_W]), 'h1F);
    chk("left8_p3c5", int'(rx[3*LINE_W+5]), 'hE0);

    run_frame("dp3", '0, 4'b1000, 1'b0, 0);
    chk("dp3_c21", int'(rx[3*LINE_W+21]), 'hF0);
    chk("dp3_c22", int'(rx[3*LINE_W+22]), 'hF0);
    chk("dp3_nonzero", nonzero(0, LINE_W-1), 2);

    ready_mode = 1;
    run_frame("backpressure", {ND{7'h7F}}, '0, 1'b0, 0);

    ready_mode = 0;
    run_frame("lz_mixed", {7'h3F, 7'h3F, 7'h06, 7'h3F}, '0, 1'b1, 0);
    chk("lz_mixed_blank_cells", nonzero(0, 2*CELL_W-1), 0);
    run_frame("lz_all0", {ND{7'h3F}}, '0, 1'b1, 0);
    chk("lz_all0_blank_cells", nonzero(0, 3*CELL_W-1), 0);
    chk("lz_all0_digit0_drawn", int'(nonzero(3*CELL_W, LINE_W-1) > 0), 1);

    // Random frames, random sink stalls, inputs disturbed mid-frame
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      logic [7*ND-1:0] s;
      logic [ND-1:0] d;
      r = $urandom; s = r[7*ND-1:0];
      if (i % 2 == 0) s[7*(ND-1) +: 7] = 7'h3F;
      r = $urandom; d = r[ND-1:0] & {ND{r[9]}};
      run_frame("random", s, d, r[4], 1);
    end

    // Reset in the middle of a frame
    ready_mode = 0;
    segments_in = {ND{7'h7F}}; dec_point_in = '0; blank_lz_in = 1'b0;
    push_frame(segments_in, dec_point_in, 1'b0);
    hs_count = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (hs_count < 50 && n < 500) begin step(); n++; end
    chk("abort_reached", int'(hs_count >= 50), 1);
    saved_done = done_cnt;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_valid", int'(byte_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(frame_done), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("abort_no_done", done_cnt, saved_done);
    run_frame("after_abort", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0010, 1'b0, 0);

    // start held high re-triggers a second frame
    segments_in = {ND{7'h6D}}; dec_point_in = 4'b0101; blank_lz_in = 1'b0;
    push_frame(segments_in, dec_point_in, 1'b0);
    push_frame(segments_in, dec_point_in, 1'b0);
    hs_count = 0;
    start = 1'b1;
    wait_done("held_first");
    step();
    start = 1'b0;
    chk("held_retrigger_busy", int'(busy), 1);
    wait_done("held_second");
    chk("held_handshakes", hs_count, 2 * FRAME);
    chk("held_queue_empty", exp_q.size(), 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
